// File: rtl/tick_counter_ud.sv
// Up/down modulo tick counter with preset load, carry/borrow pulses for cascading,
// and an optional saturating mode with a sticky done flag.
module tick_counter_ud #(
    parameter int TICK_COUNT = 100,
    parameter int WIDTH      = 7,
    parameter int WRAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tick,
    output logic             o_borrow,
    output logic [WIDTH-1:0] o_time,
    output logic             o_zero,
    output logic             o_done
);

    localparam int            CW      = $clog2(TICK_COUNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_COUNT - 1);

    logic [CW-1:0] count;
    logic          tick_q;
    logic          borrow_q;
    logic          done_q;
    logic          eff_tick;
    logic          load_clip;

    assign eff_tick  = i_en & i_tick;
    // Preset values beyond the range clamp to the top count.
    assign load_clip = (i_load_val > WIDTH'(TICK_COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            tick_q   <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            tick_q   <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (i_load) begin
            count    <= load_clip ? CNT_MAX : i_load_val[CW-1:0];
            tick_q   <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q   <= 1'b0;
            borrow_q <= 1'b0;
            if (eff_tick) begin
                if (!i_dir) begin
                    if (count != CNT_MAX) begin
                        count <= count + CW'(1);
                    end else if (WRAP != 0) begin
                        count  <= '0;
                        tick_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end else begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else if (WRAP != 0) begin
                        count    <= CNT_MAX;
                        borrow_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Pulses can only be produced in wrap mode; done only in saturate mode.
    assign o_tick   = (WRAP != 0) ? tick_q   : 1'b0;
    assign o_borrow = (WRAP != 0) ? borrow_q : 1'b0;
    assign o_done   = (WRAP != 0) ? 1'b0     : done_q;
    assign o_time   = WIDTH'(count);
    assign o_zero   = (count == '0);

endmodule

// File: tb/tb_tick_counter_ud.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus; a 60x60 cascade runs alongside.
module tb_tick_counter_ud;

    localparam int TC = 100;
    localparam int CM = 60;

    logic       clk = 1'b0;
    logic       rst, clear, en, tick, dir, load, c_tick;
    logic [7:0] load_val;

    logic       w_tk, w_bw, w_zero, w_done;
    logic [7:0] w_time;
    logic       s_tk, s_bw, s_zero, s_done;
    logic [7:0] s_time;
    logic       c1_tk, c1_bw, c1_zero, c1_done;
    logic [5:0] c1_time;
    logic       c2_tk, c2_bw, c2_zero, c2_done;
    logic [5:0] c2_time;

    always #5 clk = ~clk;

    tick_counter_ud #(.TICK_COUNT(TC), .WIDTH(8), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .i_en(en), .i_tick(tick), .i_dir(dir),
        .i_load(load), .i_load_val(load_val), .o_tick(w_tk), .o_borrow(w_bw),
        .o_time(w_time), .o_zero(w_zero), .o_done(w_done));

    tick_counter_ud #(.TICK_COUNT(TC), .WIDTH(8), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .i_en(en), .i_tick(tick), .i_dir(dir),
        .i_load(load), .i_load_val(load_val), .o_tick(s_tk), .o_borrow(s_bw),
        .o_time(s_time), .o_zero(s_zero), .o_done(s_done));

    tick_counter_ud #(.TICK_COUNT(CM), .WIDTH(6), .WRAP(1)) dut_c1 (
        .clk(clk), .rst(rst), .clear(1'b0), .i_en(1'b1), .i_tick(c_tick), .i_dir(1'b0),
        .i_load(1'b0), .i_load_val(6'd0), .o_tick(c1_tk), .o_borrow(c1_bw),
        .o_time(c1_time), .o_zero(c1_zero), .o_done(c1_done));

    tick_counter_ud #(.TICK_COUNT(CM), .WIDTH(6), .WRAP(1)) dut_c2 (
        .clk(clk), .rst(rst), .clear(1'b0), .i_en(1'b1), .i_tick(c1_tk), .i_dir(1'b0),
        .i_load(1'b0), .i_load_val(6'd0), .o_tick(c2_tk), .o_borrow(c2_bw),
        .o_time(c2_time), .o_zero(c2_zero), .o_done(c2_done));

    typedef struct {
        int w_cnt; bit w_tk; bit w_bw;
        int s_cnt; bit s_done;
        int c1; int c2; bit c1_tk; bit c2_tk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: plain integers, modulo arithmetic.
    int m_w = 0, m_s = 0, m_c1 = 0, m_c2 = 0;
    bit m_wtk = 0, m_wbw = 0, m_sdone = 0, m_c1tk = 0, m_c2tk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit l, input bit e, input bit t,
                        input bit d, input int lv, input bit ct);
        int   nxt;
        int   delta;
        bit   carry_in;
        exp_t x;
        @(negedge clk);
        rst = r; clear = c; load = l; en = e; tick = t; dir = d;
        load_val = 8'(lv); c_tick = ct;
        if (r || c) begin
            m_w = 0; m_s = 0; m_sdone = 0; m_wtk = 0; m_wbw = 0;
        end else if (l) begin
            m_w = (lv > TC - 1) ? TC - 1 : lv;
            m_s = m_w; m_sdone = 0; m_wtk = 0; m_wbw = 0;
        end else begin
            m_wtk = 0; m_wbw = 0;
            if (e && t) begin
                delta = d ? -1 : 1;
                nxt   = m_w + delta;
                m_wtk = (nxt == TC);
                m_wbw = (nxt < 0);
                m_w   = (nxt + TC) % TC;
                nxt   = m_s + delta;
                if (nxt < 0 || nxt >= TC) m_sdone = 1;
                else m_s = nxt;
            end
        end
        // Stage 2 sees the carry stage 1 is presenting right now.
        if (r) begin
            m_c1 = 0; m_c2 = 0; m_c1tk = 0; m_c2tk = 0;
        end else begin
            carry_in = m_c1tk;
            m_c2tk = 0;
            if (carry_in) begin
                m_c2 = (m_c2 + 1) % CM;
                m_c2tk = (m_c2 == 0);
            end
            m_c1tk = 0;
            if (ct) begin
                m_c1 = (m_c1 + 1) % CM;
                m_c1tk = (m_c1 == 0);
            end
        end
        x.w_cnt = m_w; x.w_tk = m_wtk; x.w_bw = m_wbw;
        x.s_cnt = m_s; x.s_done = m_sdone;
        x.c1 = m_c1; x.c2 = m_c2; x.c1_tk = m_c1tk; x.c2_tk = m_c2tk;
        q.push_back(x);
    endtask

    task automatic idle(input int n, input bit ct);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ct);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("w_time",    32'(w_time), 32'(x.w_cnt));
                chk("w_tick",    32'(w_tk),   32'(x.w_tk));
                chk("w_borrow",  32'(w_bw),   32'(x.w_bw));
                chk("w_zero",    32'(w_zero), 32'(x.w_cnt == 0));
                chk("w_done",    32'(w_done), 32'(0));
                chk("s_time",    32'(s_time), 32'(x.s_cnt));
                chk("s_done",    32'(s_done), 32'(x.s_done));
                chk("s_zero",    32'(s_zero), 32'(x.s_cnt == 0));
                chk("s_pulses",  32'({s_tk, s_bw}), 32'(0));
                chk("c1_time",   32'(c1_time), 32'(x.c1));
                chk("c2_time",   32'(c2_time), 32'(x.c2));
                chk("c1_tick",   32'(c1_tk),   32'(x.c1_tk));
                chk("c2_tick",   32'(c2_tk),   32'(x.c2_tk));
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst = 1; clear = 0; load = 0; en = 0; tick = 0; dir = 0; load_val = 0; c_tick = 0;

        // Full up sweep with carry, then down-wrap from zero.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0);
        idle(1, 0);

        // Countdown to saturation, then reload clears done.
        step(0, 0, 1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 50, 0);

        // Clamped load, then clear beats load and tick.
        step(0, 0, 1, 0, 0, 0, 200, 0);
        step(0, 1, 1, 1, 1, 0, 77, 0);
        step(0, 0, 1, 1, 1, 0, 99, 0);
        step(0, 1, 0, 1, 1, 0, 0, 0);
        idle(1, 0);

        // Ticks with enable low are lost; load beats tick; ticks gaps with direction flips.
        step(0, 0, 1, 0, 0, 0, 17, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, i % 2, 0, 0);
        step(0, 0, 1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0);

        // Reset mid-count.
        step(0, 0, 1, 0, 0, 0, 42, 1);
        step(1, 0, 0, 1, 1, 0, 0, 1);
        idle(1, 0);

        // Cascade runs a full hour of ticks back to 00:00.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CM * CM; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 0);

        // Randomised mix of every control.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 15 : 85)),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1));
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
